// File: rtl/winograd_input_tile_fetcher_if.sv
// PE input-tile bus: a 6x6 signed tile plus its map index bounds, offered
// under a valid/ready handshake. master = tile fetcher, slave = PE.
interface winograd_input_tile_fetcher_if #(
  parameter int unsigned DIM_W = 9
);
  logic signed [7:0] tile_data [0:35];
  logic              tile_valid;
  logic              tile_ready;
  logic [DIM_W-1:0]  low_width_index;
  logic [DIM_W-1:0]  high_width_index;
  logic [DIM_W-1:0]  low_height_index;
  logic [DIM_W-1:0]  high_height_index;

  modport master (
    output tile_data,
    output tile_valid,
    output low_width_index,
    output high_width_index,
    output low_height_index,
    output high_height_index,
    input  tile_ready
  );

  modport slave (
    input  tile_data,
    input  tile_valid,
    input  low_width_index,
    input  high_width_index,
    input  low_height_index,
    input  high_height_index,
    output tile_ready
  );
endinterface

// File: rtl/winograd_input_tile_fetcher.sv
// Winograd input-tile fetcher: walks a single-channel feature map in an 8-bit
// SRAM, gathers 6x6 tiles at stride 4 (zero-filled outside the map) and hands
// each one to a PE over the tile bus.
module winograd_input_tile_fetcher #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [DIM_W-1:0]              fm_width,
  input  logic [DIM_W-1:0]              fm_height,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic signed [7:0]             mem_rd_data,
  winograd_input_tile_fetcher_if.master tile,
  output logic                          busy,
  output logic                          done
);

  // Coordinates reach 4*ty+5, so two bits wider than a dimension.
  localparam int unsigned CW    = DIM_W + 2;
  // r*W + c needs CW + DIM_W bits.
  localparam int unsigned OFF_W = 2 * DIM_W + 2;

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StEmit, StDone} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [DIM_W-1:0]   tx_q, ty_q;
  logic [5:0]         k_q;
  logic [2:0]         rr_q, cc_q;   // k_q / 6 and k_q % 6, tracked incrementally
  logic [5:0]         k_dly;
  logic               zero_dly;
  logic               wr_dly;

  logic [DIM_W:0]     tiles_x, tiles_y;
  logic               last_x, last_y;
  logic [CW-1:0]      org_x, org_y, row, col;
  logic [CW-1:0]      hi_w_cand, hi_h_cand, w_max, h_max;
  logic               in_bounds;
  logic [OFF_W-1:0]   offset;

  assign tiles_x = ({1'b0, w_q} + (DIM_W+1)'(3)) >> 2;
  assign tiles_y = ({1'b0, h_q} + (DIM_W+1)'(3)) >> 2;
  assign last_x  = ({1'b0, tx_q} + (DIM_W+1)'(1)) >= tiles_x;
  assign last_y  = ({1'b0, ty_q} + (DIM_W+1)'(1)) >= tiles_y;

  assign org_x     = {tx_q, 2'b00};
  assign org_y     = {ty_q, 2'b00};
  assign row       = org_y + CW'(rr_q);
  assign col       = org_x + CW'(cc_q);
  assign in_bounds = (row < CW'(h_q)) && (col < CW'(w_q));

  // Offset kept wide; only the final base add wraps to the address width.
  assign offset    = OFF_W'(row) * OFF_W'(w_q) + OFF_W'(col);
  assign mem_rd_en = (state_q == StFetch) && in_bounds;
  assign mem_addr  = mem_rd_en ? base_q + ADDR_W'(offset) : '0;

  assign hi_w_cand = org_x + CW'(5);
  assign hi_h_cand = org_y + CW'(5);
  assign w_max     = CW'(w_q) - CW'(1);
  assign h_max     = CW'(h_q) - CW'(1);

  // Read-data capture: the element issued last cycle lands in its tile slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_dly   <= 1'b0;
      zero_dly <= 1'b0;
      k_dly    <= '0;
      for (int i = 0; i < 36; i++) begin
        tile.tile_data[i] <= '0;
      end
    end else begin
      wr_dly   <= (state_q == StFetch);
      zero_dly <= !in_bounds;
      k_dly    <= k_q;
      if (wr_dly) begin
        tile.tile_data[k_dly] <= zero_dly ? 8'sd0 : mem_rd_data;
      end
    end
  end

  // Control FSM with registered handshake, index and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                <= StIdle;
      base_q                 <= '0;
      w_q                    <= '0;
      h_q                    <= '0;
      tx_q                   <= '0;
      ty_q                   <= '0;
      k_q                    <= '0;
      rr_q                   <= '0;
      cc_q                   <= '0;
      tile.tile_valid        <= 1'b0;
      tile.low_width_index   <= '0;
      tile.high_width_index  <= '0;
      tile.low_height_index  <= '0;
      tile.high_height_index <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q <= base_addr;
            w_q    <= fm_width;
            h_q    <= fm_height;
            tx_q   <= '0;
            ty_q   <= '0;
            k_q    <= '0;
            rr_q   <= '0;
            cc_q   <= '0;
            busy   <= 1'b1;
            if (fm_width == '0 || fm_height == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          if (k_q == 6'd35) begin
            state_q <= StDrain;
          end else begin
            k_q <= k_q + 6'd1;
            if (cc_q == 3'd5) begin
              cc_q <= '0;
              rr_q <= rr_q + 3'd1;
            end else begin
              cc_q <= cc_q + 3'd1;
            end
          end
        end
        // Last element's read data arrives during this cycle.
        StDrain: begin
          state_q                <= StEmit;
          tile.tile_valid        <= 1'b1;
          tile.low_width_index   <= DIM_W'(org_x);
          tile.high_width_index  <= DIM_W'((hi_w_cand < w_max) ? hi_w_cand : w_max);
          tile.low_height_index  <= DIM_W'(org_y);
          tile.high_height_index <= DIM_W'((hi_h_cand < h_max) ? hi_h_cand : h_max);
        end
        StEmit: begin
          if (tile.tile_ready) begin
            tile.tile_valid <= 1'b0;
            k_q             <= '0;
            rr_q            <= '0;
            cc_q            <= '0;
            if (!last_x) begin
              tx_q    <= tx_q + 1'b1;
              state_q <= StFetch;
            end else if (!last_y) begin
              tx_q    <= '0;
              ty_q    <= ty_q + 1'b1;
              state_q <= StFetch;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
